// File: rtl/des_io_pkg.sv
// Shared widths and the left/right half pair for the DES block I/O path.
package des_io_pkg;

    localparam int unsigned BLOCK_W     = 64;
    localparam int unsigned HALF_W      = 32;
    localparam int unsigned BLOCK_BYTES = 8;
    localparam int unsigned IDX_W       = $clog2(BLOCK_BYTES);

    typedef struct packed {
        logic [HALF_W-1:0] left;
        logic [HALF_W-1:0] right;
    } half_pair_t;

    // Upper word of the block becomes the left half.
    function automatic half_pair_t split_block(input logic [BLOCK_W-1:0] blk);
        return half_pair_t'(blk);
    endfunction

endpackage

// File: rtl/des_byte_assembler.sv
// Collects bytes MSB-first into a 64-bit block and holds one completed
// block in place while the output slot is busy.
module des_byte_assembler
    import des_io_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    input  logic               slot_free,
    output logic               load,
    output logic [BLOCK_W-1:0] load_data,
    output logic               partial
);

    logic [IDX_W-1:0]   idx;
    logic [BLOCK_W-1:0] shreg;
    logic               asm_full;
    logic               accept;
    logic               last;
    logic [BLOCK_W-1:0] assembled;

    assign accept     = byte_valid && !asm_full && !clear;
    assign last       = (idx == IDX_W'(BLOCK_BYTES - 1));
    assign assembled  = {shreg[BLOCK_W-9:0], byte_in};
    assign byte_ready = !asm_full;
    assign partial    = (idx != '0) && !asm_full;

    // A completing byte bypasses the shift register when the slot is free.
    assign load      = !clear && slot_free && (asm_full || (accept && last));
    assign load_data = asm_full ? shreg : assembled;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            shreg    <= '0;
            asm_full <= 1'b0;
        end else if (clear) begin
            idx      <= '0;
            asm_full <= 1'b0;
        end else begin
            if (accept) begin
                shreg <= assembled;
                idx   <= idx + IDX_W'(1);
            end
            if (asm_full && slot_free) begin
                asm_full <= 1'b0;
            end else if (accept && last && !slot_free) begin
                asm_full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/des_block_loader.sv
// Byte-to-block loader: presents assembled 64-bit blocks as left/right
// halves over a valid/ready handshake and counts delivered blocks.
module des_block_loader
    import des_io_pkg::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic [HALF_W-1:0]  left_out,
    output logic [HALF_W-1:0]  right_out,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic               partial,
    output logic [COUNT_W-1:0] blk_count
);

    logic               slot_free;
    logic               handshake;
    logic               load;
    logic [BLOCK_W-1:0] load_data;
    half_pair_t         load_pair;

    assign slot_free = !blk_valid || blk_ready;
    assign handshake = blk_valid && blk_ready && !clear;
    assign load_pair = split_block(load_data);

    des_byte_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .slot_free  (slot_free),
        .load       (load),
        .load_data  (load_data),
        .partial    (partial)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_out  <= '0;
            right_out <= '0;
            blk_valid <= 1'b0;
            blk_count <= '0;
        end else begin
            if (clear) begin
                blk_valid <= 1'b0;
            end else if (load) begin
                left_out  <= load_pair.left;
                right_out <= load_pair.right;
                blk_valid <= 1'b1;
            end else if (handshake) begin
                blk_valid <= 1'b0;
            end
            if (handshake) begin
                blk_count <= blk_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: doc/des_block_loader.md
# des_block_loader

Input-side loader for the DES/LFSR Feistel datapath. It accepts plaintext or ciphertext one byte at a time and assembles each 64-bit block. The block is split into the initial left/right 32-bit halves (left = upper word) and presented to the Feistel core over a valid/ready handshake. A one-block staging buffer lets byte collection continue while the core back-pressures.

## Interface
- COUNT_W, 16, width of the completed-block counter.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush: drops the partial block, staged block and pending output.
- byte_in  input  8  data byte; the first byte of a block is block[63:56].
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can take a byte; byte accepted on byte_valid && byte_ready.
- left_out  output  32  block[63:32] of the presented block.
- right_out  output  32  block[31:0] of the presented block.
- blk_valid  output  1  left_out/right_out hold a block.
- blk_ready  input  1  core takes the block on blk_valid && blk_ready.
- partial  output  1  1 to 7 bytes of the current block have been collected.
- blk_count  output  COUNT_W  number of output handshakes; wraps modulo 2^COUNT_W.

## Operation
- Assembly: 3-bit byte index `idx` and 64-bit shift register; each accepted byte shifts in at the LSB end (MSB-first order). `idx` increments on every accept and wraps 7→0.
- Output slot: registers left_out, right_out, blk_valid. The slot can load when `!blk_valid || blk_ready`.
- 8th byte accepted (idx==7):
  - slot can load → the full block (including this byte) loads directly into the slot.
  - otherwise → the block is held in the shift register and `asm_full` is set.
- byte_ready = !asm_full (combinational). While asm_full is set, no bytes are accepted.
- asm_full set and slot can load → transfer to the slot; asm_full clears the same edge.
- Output handshake with no new load that cycle → blk_valid clears. Handshake and load in the same cycle → blk_valid stays 1 and the slot holds the new data.
- Every output handshake increments blk_count; the counter wraps and does not saturate.
- partial = (idx != 0) && !asm_full.
- clear has highest priority over all other actions in the cycle.
  - Zeroes idx, asm_full and blk_valid.
  - A byte or output handshake in the same cycle is discarded and not counted.
  - blk_count and the data registers are unchanged.
- left_out and right_out are meaningful only while blk_valid=1; they hold their last value otherwise.

## Timing
- Reset values (rst_n low, asynchronous):
  - left_out=0, right_out=0, blk_valid=0, blk_count=0, partial=0.
  - idx=0, asm_full=0, so byte_ready=1.
- Latency: 8th byte accepted at edge N with the slot free → blk_valid=1 after edge N (visible in cycle N+1).
- Staged path: slot busy at edge N, first slot-free edge M → block visible after M.
- Throughput: with blk_ready tied high, byte_ready stays 1 continuously. One block per 8 byte cycles, no bubbles.
- Worst-case holding: one block in the slot plus one in staging. byte_ready drops after the second block completes and rises after the edge on which the slot takes the staged block.
- byte_valid without byte_ready: the byte is held by the upstream source and not sampled.
- rst_n asserted mid-block: all state is lost immediately and no partial block survives. Behaviour after release is identical to power-up.

## Structure
- Shared package `des_io_pkg`:
  - BLOCK_W=64, HALF_W=32, BLOCK_BYTES=8.
  - A typedef for the left/right half pair.
- This block and the output register both import the package.
- One natural sub-module: `des_byte_assembler` (shift register, idx, asm_full, partial). The top level holds the output slot, the transfer/bypass decision and blk_count.

## Test plan
- Bytes 0x01..0x08 on consecutive cycles with blk_ready=1:
  - Cycle after the 8th byte: left_out=0x01020304, right_out=0x05060708, blk_valid=1 for one cycle.
  - blk_count=1.
- blk_ready=0 while sending 16 bytes 0x00..0x0F:
  - byte_ready goes 0 after byte 0x0F is accepted; slot shows 0x00010203/0x04050607.
  - Raise blk_ready: the next block 0x08090A0B/0x0C0D0E0F appears on the following cycle.
  - byte_ready returns to 1; blk_count=2.
- Send 3 bytes (partial=1), pulse clear, then send 0xAA×8:
  - Output is 0xAAAAAAAA/0xAAAAAAAA; partial=0 after clear.
- clear asserted in the same cycle as an output handshake:
  - blk_valid=0 next cycle; blk_count is not incremented.
- Drop rst_n for one cycle after 5 bytes:
  - All outputs at reset values and byte_ready=1.
  - The next 8 bytes form a clean block.
- COUNT_W=2, stream 5 blocks with blk_ready=1:
  - blk_count sequence 1,2,3,0,1.
  - Throughput is one block per 8 cycles, with no byte_ready drop.
